fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
// Round-robin write arbiter sharing the single write port of the sync FIFO between NUM_REQ producers.
// Sits between producer blocks and the FIFO: registers one winner's data onto data_in/wr_en per cycle.
// Uses full/almostfull from the FIFO to throttle, so no write is ever issued into a full FIFO.
// Keeps a wrapping write counter and a sticky error flag for the scoreboard and coverage.
// PARAMETERS
// NUM_REQ     4   number of requesters (2..8)
// DATA_WIDTH  16  FIFO data width
// CNT_WIDTH   16  width of wr_count
// PORTS
// clk             in   1                   clock, all logic on posedge
// rst_n           in   1                   asynchronous active-low reset
// req_valid       in   NUM_REQ             per-requester write request, held until granted
// req_data        in   NUM_REQ*DATA_WIDTH  requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH]
// req_grant       out  NUM_REQ             one-hot, high in the cycle that requester's data is on wr_en/data_in
// wr_en           out  1                   to FIFO wr_en
// data_in         out  DATA_WIDTH          to FIFO data_in
// full            in   1                   from FIFO
// almostfull      in   1                   from FIFO (count == DEPTH-1)
// wr_ack          in   1                   from FIFO, counted
// overflow        in   1                   from FIFO, error monitor
// arb_state       out  2                   00 IDLE, 01 GRANT, 10 STALL
// wr_count        out  CNT_WIDTH           number of wr_ack pulses seen, wraps to 0
// overflow_err    out  1                   sticky: overflow seen
// BEHAVIOUR
// - Reset (async, rst_n=0): wr_en=0, data_in=0, req_grant=0, arb_state=IDLE, wr_count=0, overflow_err=0, rr pointer=0.
// - All outputs are registered. The decision made at edge k drives wr_en, data_in and req_grant for cycle k..k+1.
// - Eligible(i) = req_valid[i] && !(req_grant[i]). The requester granted in the current cycle is never eligible at the next edge.
//   Consequence: a single active requester gets at most 1 write every 2 cycles.
// - blocked = full || (almostfull && wr_en). The in-flight write fills the last slot.
// - At each posedge:
//   - If blocked or no eligible requester: wr_en=0, req_grant=0.
//   - Otherwise pick the first eligible index searching ptr, ptr+1, ... mod NUM_REQ.
//     Then wr_en=1, req_grant=onehot(win), data_in=req_data[win], ptr=(win+1) mod NUM_REQ.
//   - ptr is unchanged when nothing is granted.
// - Requester handshake: hold valid/data stable until the cycle req_grant[i]=1. It may change them at the following edge.
//   Dropping valid before the grant is legal (the request is withdrawn).
// - FSM, evaluated with the same inputs as the grant:
//   - IDLE: no req_valid asserted.
//   - GRANT: a grant was issued.
//   - STALL: some req_valid asserted but blocked, or only the just-granted requester is valid.
//   - Transitions:
//     - any state -> GRANT when a grant is issued.
//     - any state -> STALL when any valid but no grant.
//     - any state -> IDLE when no valid.
// - wr_count increments by 1 each posedge where wr_ack=1. It wraps from 2^CNT_WIDTH-1 to 0.
// - overflow_err is set on any posedge with overflow=1 and is cleared only by reset.
// - Reset mid-operation: all outputs return to reset values immediately. Pending requests are re-arbitrated from ptr=0 after release.
// - Simultaneous full deassert and new valid: the decision uses the values sampled at the edge. No lookahead.
// TESTING
// T1 reset: assert rst_n=0 mid-grant -> wr_en, req_grant and wr_count read 0 before the next clk edge. arb_state=IDLE.
// T2 fairness: all 4 req_valid held high, FIFO never full -> grants rotate in order 0,1,2,3,0...
//    (no requester granted in consecutive cycles). Data order on data_in matches.
// T3 single requester: only req 2 valid for 10 cycles -> wr_en pattern 1,0,1,0...
//    5 writes, arb_state alternates GRANT/STALL.
// T4 fill: DEPTH=8 FIFO, no reads, 4 requesters continuously valid.
//    -> exactly 8 wr_en pulses, then wr_en=0 and arb_state=STALL. overflow_err stays 0.
// T5 drain resume: from T4, pulse one FIFO read -> exactly one further write.
//    Grant goes to the requester at ptr. wr_count=9.
// T6 counter wrap: CNT_WIDTH=4, 17 acked writes -> wr_count reads 1.
//    Force overflow=1 for one cycle -> overflow_err=1 until rst_n=0.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of the producer-side request bus and the FIFO write-port signals
// shared between fifo_wr_arbiter and its environment.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_grant;
  logic                          wr_en;
  logic [DATA_WIDTH-1:0]         data_in;
  logic                          full;
  logic                          almostfull;
  logic                          wr_ack;
  logic                          overflow;
  logic [1:0]                    arb_state;
  logic [CNT_WIDTH-1:0]          wr_count;
  logic                          overflow_err;

  // Environment side: producers and FIFO status drive, arbiter results observed.
  modport master (
    output req_valid, req_data, full, almostfull, wr_ack, overflow,
    input  req_grant, wr_en, data_in, arb_state, wr_count, overflow_err
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, full, almostfull, wr_ack, overflow,
    output req_grant, wr_en, data_in, arb_state, wr_count, overflow_err
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: shares one FIFO write port between NUM_REQ
// producers, throttled by full/almostfull so the FIFO is never overrun.
// Also counts write acknowledges and latches a sticky overflow error.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input logic              clk,
  input logic              rst_n,
  fifo_wr_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    STALL = 2'b10
  } arb_state_t;

  arb_state_t            state_q;
  logic [PTR_W-1:0]      ptr_q;
  logic [NUM_REQ-1:0]    grant_q;
  logic                  wr_en_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  ovf_err_q;

  logic [NUM_REQ-1:0]    eligible;
  logic                  blocked;
  logic                  found;
  logic [PTR_W-1:0]      win;
  logic [PTR_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] win_data;

  function automatic logic [PTR_W-1:0] wrap_idx(input int unsigned v);
    return PTR_W'(v % NUM_REQ);
  endfunction

  // Find the first eligible requester at or after the pointer; scanning offsets
  // from the far end down lets the nearest hit overwrite the others.
  always_comb begin
    eligible = bus.req_valid & ~grant_q;
    blocked  = bus.full | (bus.almostfull & wr_en_q);
    found    = 1'b0;
    win      = ptr_q;
    idx      = ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = wrap_idx(32'(ptr_q) + 32'(k));
      if (eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Select the winning requester's data word.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PTR_W'(i) == win) begin
        win_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Register the grant decision, write strobe, data and arbiter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      state_q <= IDLE;
    end else if (!blocked && found) begin
      wr_en_q <= 1'b1;
      data_q  <= win_data;
      grant_q <= NUM_REQ'(1) << win;
      ptr_q   <= wrap_idx(32'(win) + 32'd1);
      state_q <= GRANT;
    end else begin
      wr_en_q <= 1'b0;
      grant_q <= '0;
      state_q <= (|bus.req_valid) ? STALL : IDLE;
    end
  end

  // Count acknowledged writes (wrapping) and latch any FIFO overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      ovf_err_q <= 1'b0;
    end else begin
      if (bus.wr_ack) begin
        count_q <= count_q + CNT_WIDTH'(1);
      end
      if (bus.overflow) begin
        ovf_err_q <= 1'b1;
      end
    end
  end

  assign bus.wr_en        = wr_en_q;
  assign bus.data_in      = data_q;
  assign bus.req_grant    = grant_q;
  assign bus.arb_state    = state_q;
  assign bus.wr_count     = count_q;
  assign bus.overflow_err = ovf_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: producers and an 8-deep FIFO are
// modelled here, and every cycle the DUT outputs are compared with a
// behavioural reference of the arbitration rules.
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int DW        = 16;
  localparam int CW        = 4;
  localparam int DEPTH     = 8;
  localparam int NCYC      = 1200;
  localparam int OVF_CYC   = 700;
  localparam int RESET_CYC = 1000;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model state: what the outputs should be in the current cycle
  logic            m_wr_en;
  logic [DW-1:0]   m_data;
  logic [NREQ-1:0] m_grant;
  int              m_ptr;
  int              m_state;
  int              m_count;
  logic            m_ovf_err;

  // producers
  logic [NREQ-1:0] valid;
  logic [DW-1:0]   rdata [NREQ];

  // FIFO environment
  logic [DW-1:0] fifo_q [$];
  logic          ack_pend;
  logic          ovf_pend;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic resetModel();
    m_wr_en   = 1'b0;
    m_data    = '0;
    m_grant   = '0;
    m_ptr     = 0;
    m_state   = 0;
    m_count   = 0;
    m_ovf_err = 1'b0;
  endtask

  task automatic driveRequests();
    bus.req_valid = valid;
    for (int i = 0; i < NREQ; i++) bus.req_data[i*DW +: DW] = rdata[i];
  endtask

  // Called at a negedge: check current outputs, drive inputs for the next
  // posedge and advance the reference model and FIFO across that edge.
  task automatic applyStimulus(input int cyc);
    logic            full_s, afull_s, blocked, rd, ovf_in, old_wr_en;
    logic [DW-1:0]   old_data;
    logic [NREQ-1:0] elig;
    int              best, bestd, d, sz;

    checkOutput("wr_en", 32'(bus.wr_en), 32'(m_wr_en));
    checkOutput("req_grant", 32'(bus.req_grant), 32'(m_grant));
    checkOutput("arb_state", 32'(bus.arb_state), 32'(m_state));
    checkOutput("wr_count", 32'(bus.wr_count), 32'(m_count));
    checkOutput("overflow_err", 32'(bus.overflow_err), 32'(m_ovf_err));
    if (m_wr_en) checkOutput("data_in", 32'(bus.data_in), 32'(m_data));

    for (int i = 0; i < NREQ; i++) begin
      if (valid[i] && !m_grant[i]) begin
        if (cyc >= 40 && $urandom_range(15) == 0) valid[i] = 1'b0;
      end else begin
        if (cyc < 40 || (cyc >= 300 && cyc < 600)) valid[i] = 1'b1;
        else valid[i] = ($urandom_range(1) == 1);
        rdata[i] = DW'($urandom);
      end
    end
    driveRequests();

    sz      = fifo_q.size();
    full_s  = (sz == DEPTH);
    afull_s = (sz == DEPTH - 1);
    if (cyc < 300)      rd = ($urandom_range(7) != 0);
    else if (cyc < 600) rd = 1'b0;
    else if (cyc < 900) rd = ($urandom_range(3) == 0);
    else                rd = ($urandom_range(1) == 0);
    ovf_in = ovf_pend || (cyc == OVF_CYC);

    bus.full       = full_s;
    bus.almostfull = afull_s;
    bus.wr_ack     = ack_pend;
    bus.overflow   = ovf_in;

    m_count = (m_count + (ack_pend ? 1 : 0)) % (1 << CW);
    if (ovf_in) m_ovf_err = 1'b1;

    old_wr_en = m_wr_en;
    old_data  = m_data;
    elig      = valid & ~m_grant;
    blocked   = full_s || (afull_s && m_wr_en);
    best      = -1;
    bestd     = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      d = (i - m_ptr + NREQ) % NREQ;
      if (elig[i] && d < bestd) begin
        bestd = d;
        best  = i;
      end
    end
    if (!blocked && best >= 0) begin
      m_wr_en = 1'b1;
      m_grant = NREQ'(1) << best;
      m_data  = rdata[best];
      m_ptr   = (best + 1) % NREQ;
      m_state = 1;
    end else begin
      m_wr_en = 1'b0;
      m_grant = '0;
      m_state = (valid != '0) ? 2 : 0;
    end

    ack_pend = old_wr_en && (sz < DEPTH);
    ovf_pend = old_wr_en && (sz >= DEPTH);
    if (rd && sz > 0) void'(fifo_q.pop_front());
    if (old_wr_en && sz < DEPTH) fifo_q.push_back(old_data);
  endtask

  initial begin
    rst_n    = 1'b0;
    valid    = '0;
    for (int i = 0; i < NREQ; i++) rdata[i] = '0;
    driveRequests();
    bus.full       = 1'b0;
    bus.almostfull = 1'b0;
    bus.wr_ack     = 1'b0;
    bus.overflow   = 1'b0;
    ack_pend = 1'b0;
    ovf_pend = 1'b0;
    resetModel();

    repeat (2) @(negedge clk);
    checkOutput("init_wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("init_data_in", 32'(bus.data_in), 32'd0);
    checkOutput("init_req_grant", 32'(bus.req_grant), 32'd0);
    checkOutput("init_arb_state", 32'(bus.arb_state), 32'd0);
    checkOutput("init_wr_count", 32'(bus.wr_count), 32'd0);
    checkOutput("init_overflow_err", 32'(bus.overflow_err), 32'd0);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      applyStimulus(cyc);
      @(posedge clk);
      if (cyc == RESET_CYC) begin
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_wr_en", 32'(bus.wr_en), 32'd0);
        checkOutput("rst_data_in", 32'(bus.data_in), 32'd0);
        checkOutput("rst_req_grant", 32'(bus.req_grant), 32'd0);
        checkOutput("rst_arb_state", 32'(bus.arb_state), 32'd0);
        checkOutput("rst_wr_count", 32'(bus.wr_count), 32'd0);
        checkOutput("rst_overflow_err", 32'(bus.overflow_err), 32'd0);
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
